// File: rtl/apb_pkg.sv
// Shared APB definitions: completer FSM states and bus geometry.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } apb_state_e;

  localparam int unsigned APB_ADDR_W  = 9;
  localparam int unsigned APB_DATA_W  = 8;
  localparam int unsigned APB_SEL_BIT = 8;

endpackage

// File: rtl/apb_slave_regfile.sv
// Byte memory with per-location written flags; combinational read, clocked write.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = APB_DATA_W,
  parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic              rd_in_range;

  // Contents survive reset; only the written flags are cleared.
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) valid <= '0;
    else if (we) valid[wr_idx] <= 1'b1;
  end

  always_comb begin
    rd_in_range = 32'(rd_idx) < DEPTH;
    rd_data     = rd_in_range ? mem[rd_idx] : '0;
    rd_valid    = rd_in_range ? valid[rd_idx] : 1'b0;
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer fronting a small byte memory, with fixed wait states and PSLVERR.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int unsigned OFF_W = ADDR_W - 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_state_e        state;
  logic [3:0]        cnt;
  logic              lat_wr;
  logic              lat_err;
  logic [IDX_W-1:0]  lat_idx;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] lat_rdata;

  logic [OFF_W-1:0]  setup_off;
  logic [IDX_W-1:0]  setup_idx;
  logic              setup_err;
  logic [DATA_W-1:0] setup_rdata;
  logic [DATA_W-1:0] rf_rd_data;
  logic              rf_rd_valid;
  logic              we;
  logic              unused_sel;

  // The slave-select bit is consumed by the master's decode, not here.
  assign unused_sel = PADDR[ADDR_W-1];

  always_comb begin
    setup_off   = PADDR[ADDR_W-2:0];
    setup_idx   = setup_off[IDX_W-1:0];
    setup_err   = !(32'(setup_off) < DEPTH) || (!PWRITE && !rf_rd_valid);
    setup_rdata = (setup_err || PWRITE) ? '0 : rf_rd_data;
    we          = (state == RESP) && PSEL && PENABLE && lat_wr && !lat_err && !PRESET;
  end

  apb_slave_regfile #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk      (PCLK),
    .rst      (PRESET),
    .we       (we),
    .wr_idx   (lat_idx),
    .wr_data  (lat_wdata),
    .rd_idx   (setup_idx),
    .rd_data  (rf_rd_data),
    .rd_valid (rf_rd_valid)
  );

  // Read data and error are resolved at the setup edge so the response is purely registered.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_wr    <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_rdata <= '0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      PRDATA    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            lat_wr    <= PWRITE;
            lat_err   <= setup_err;
            lat_idx   <= setup_idx;
            lat_wdata <= PWDATA;
            lat_rdata <= setup_rdata;
            cnt       <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state   <= RESP;
              PREADY  <= 1'b1;
              PSLVERR <= setup_err;
              PRDATA  <= setup_rdata;
            end else begin
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!PSEL) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state   <= RESP;
              PREADY  <= 1'b1;
              PSLVERR <= lat_err;
              PRDATA  <= lat_rdata;
            end
          end
        end
        RESP: begin
          if (!PSEL || PENABLE) begin
            state   <= IDLE;
            cnt     <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= '0;
        end
      endcase
    end
  end

endmodule
